// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - sweeper handshake and DUT-drive bundle
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    truth_table;
  logic            table_valid;
  logic            match;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, truth_table, table_valid, match
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, truth_table, table_valid, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives every input vector into a gate and rebuilds its truth-table code
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  truth_table_sweeper_if.slave      bus
);
  localparam int W = 1 << N_IN;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST   = N_IN'(W - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    table_q, table_d;
  logic [W-1:0]    exp_q, exp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            match_q, match_d;

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    exp_d    = exp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    match_d  = match_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SETTLE;
          dut_in_d = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          match_d  = 1'b0;
          table_d  = '0;
          cnt_d    = RELOAD;
          exp_d    = bus.expected;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          // Inverting the vector gives W-1-v, so vector 0 lands in the MSB.
          table_d[~dut_in_q] = bus.dut_out;
          if (dut_in_q != LAST) begin
            dut_in_d = dut_in_q + 1'b1;
            cnt_d    = RELOAD;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            match_d = (table_d == exp_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      cnt_q    <= '0;
      table_q  <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      table_q  <= table_d;
      exp_q    <= exp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
    end
  end

  assign bus.dut_in      = dut_in_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = table_q;
  assign bus.table_valid = valid_q;
  assign bus.match       = match_q;
endmodule
